// File: rtl/regfile_bus_pkg.sv
// regfile_bus_pkg: FSM state encoding and width helpers shared by the register-file bus master.
package regfile_bus_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_RESP,
        S_MODIFY
    } state_t;

    function automatic int addr_width(input int reg_count);
        return (reg_count > 2) ? $clog2(reg_count) : 1;
    endfunction

    // The latency counter only has to hold read_latency-1.
    function automatic int count_width(input int read_latency);
        return (read_latency > 2) ? $clog2(read_latency) : 1;
    endfunction
endpackage

// File: rtl/rbm_latency_counter.sv
// rbm_latency_counter: loadable down-counter that stops at zero and flags it.
module rbm_latency_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - W'(1);
    end

    assign zero = (count == '0);
endmodule

// File: rtl/regfile_bus_master.sv
// regfile_bus_master: single-outstanding command initiator for a register-file access port.
// Define REGMASTER_RMW_EN to add In_CmdMask and masked read-modify-write.
module regfile_bus_master
    import regfile_bus_pkg::*;
#(
    parameter int P_RegCount    = 3,
    parameter int P_BitWidth    = 32,
    parameter int P_ReadLatency = 1,
    localparam int AW = addr_width(P_RegCount),
    localparam int BW = P_BitWidth
) (
    input  logic          In_Clock,
    input  logic          In_Reset,
    input  logic          In_CmdValid,
    output logic          Out_CmdReady,
    input  logic          In_CmdWrite,
    input  logic [AW-1:0] In_CmdAddr,
    input  logic [BW-1:0] In_CmdData,
`ifdef REGMASTER_RMW_EN
    input  logic [BW-1:0] In_CmdMask,
`endif
    output logic          Out_RspValid,
    input  logic          In_RspReady,
    output logic [BW-1:0] Out_RspData,
    output logic          Out_RspError,
    output logic [AW-1:0] Out_Address,
    output logic [BW-1:0] Out_WriteData,
    output logic          Out_Write,
    output logic          Out_Read,
    input  logic [BW-1:0] In_ReadData
);
    localparam int CW = count_width(P_ReadLatency);

    state_t        state, state_n;
    logic          accept, zero, full_write, rmw_pending;
    logic [AW-1:0] addr_n;
    logic [BW-1:0] wdata_n, rsp_data_n;
    logic          rsp_error_n;

    assign accept = In_CmdValid & Out_CmdReady;

`ifdef REGMASTER_RMW_EN
    logic          rmw_flag;
    logic [BW-1:0] cmd_data, cmd_mask, merged;

    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            rmw_flag <= 1'b0;
            cmd_data <= '0;
            cmd_mask <= '0;
        end else if (accept) begin
            rmw_flag <= In_CmdWrite & ~full_write;
            cmd_data <= In_CmdData;
            cmd_mask <= In_CmdMask;
        end
    end

    // Out_RspData already holds the value read in WAIT while the merge is formed.
    assign full_write  = &In_CmdMask;
    assign rmw_pending = rmw_flag;
    assign merged      = (Out_RspData & ~cmd_mask) | (cmd_data & cmd_mask);
`else
    assign full_write  = 1'b1;
    assign rmw_pending = 1'b0;
`endif

    rbm_latency_counter #(.W(CW)) u_latency (
        .clk  (In_Clock),
        .rst  (In_Reset),
        .load (state == S_READ),
        .value(CW'(P_ReadLatency - 1)),
        .zero (zero)
    );

    always_comb begin
        state_n     = state;
        addr_n      = Out_Address;
        wdata_n     = Out_WriteData;
        rsp_data_n  = Out_RspData;
        rsp_error_n = Out_RspError;
        case (state)
            S_IDLE: if (accept) begin
                rsp_error_n = 1'b0;
                if (int'(In_CmdAddr) >= P_RegCount) begin
                    state_n     = S_RESP;
                    rsp_error_n = 1'b1;
                    rsp_data_n  = '0;
                end else begin
                    state_n = (In_CmdWrite && full_write) ? S_WRITE : S_READ;
                    addr_n  = In_CmdAddr;
                    wdata_n = (In_CmdWrite && full_write) ? In_CmdData : Out_WriteData;
                end
            end
            S_WRITE: begin
                state_n    = S_RESP;
                rsp_data_n = Out_WriteData;
            end
            S_READ: state_n = S_WAIT;
            S_WAIT: if (zero) begin
                state_n    = rmw_pending ? S_MODIFY : S_RESP;
                rsp_data_n = In_ReadData;
            end
`ifdef REGMASTER_RMW_EN
            S_MODIFY: begin
                state_n = S_WRITE;
                wdata_n = merged;
            end
`endif
            S_RESP: if (In_RspReady) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            state         <= S_IDLE;
            Out_CmdReady  <= 1'b0;
            Out_Write     <= 1'b0;
            Out_Read      <= 1'b0;
            Out_RspValid  <= 1'b0;
            Out_RspData   <= '0;
            Out_RspError  <= 1'b0;
            Out_Address   <= '0;
            Out_WriteData <= '0;
        end else begin
            state         <= state_n;
            Out_CmdReady  <= (state_n == S_IDLE);
            Out_Write     <= (state_n == S_WRITE);
            Out_Read      <= (state_n == S_READ);
            Out_RspValid  <= (state_n == S_RESP);
            Out_RspData   <= rsp_data_n;
            Out_RspError  <= rsp_error_n;
            Out_Address   <= addr_n;
            Out_WriteData <= wdata_n;
        end
    end
endmodule
